// File: rtl/reg_ctrl_pkg.sv
// reg_ctrl_pkg
// Holds the items that the register-control command decoder and its bench
// both use: the decoder state encoding, the frame command bytes, and the
// error byte that is transmitted when REG_CTRL_ERR_EN is defined.
package reg_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_TX_WAIT
    } state_t;

    localparam logic [7:0] CMD_WR   = 8'hAA;
    localparam logic [7:0] CMD_RD   = 8'hBB;
    localparam logic [7:0] ERR_CODE = 8'hEE;

endpackage

// File: rtl/reg_ctrl_if.sv
// reg_ctrl_if
// Bundles the signals between the command decoder and its neighbours.
//   Receive path   : i_rx_data, i_rx_valid          (into the decoder)
//   Register file  : o_addr, o_wr_en, o_rd_en, o_wr_data (out of the decoder)
//                    i_rd_data, i_rd_valid           (into the decoder)
//   Transmit path  : o_tx_data, o_tx_valid          (out of the decoder)
//                    i_tx_busy                       (into the decoder)
// modport master : the decoder side (reg_ctrl)
// modport slave  : the surrounding RX / register file / TX side
interface reg_ctrl_if #(
    parameter int WIDTH_REG = 8,
    parameter int ADDR      = 4
) ();

    logic [WIDTH_REG-1:0] i_rx_data;
    logic                 i_rx_valid;
    logic [ADDR-1:0]      o_addr;
    logic                 o_wr_en;
    logic                 o_rd_en;
    logic [WIDTH_REG-1:0] o_wr_data;
    logic [WIDTH_REG-1:0] i_rd_data;
    logic                 i_rd_valid;
    logic [WIDTH_REG-1:0] o_tx_data;
    logic                 o_tx_valid;
    logic                 i_tx_busy;

    modport master (
        input  i_rx_data, i_rx_valid, i_rd_data, i_rd_valid, i_tx_busy,
        output o_addr, o_wr_en, o_rd_en, o_wr_data, o_tx_data, o_tx_valid
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_rd_data, i_rd_valid, i_tx_busy,
        input  o_addr, o_wr_en, o_rd_en, o_wr_data, o_tx_data, o_tx_valid
    );

endinterface

// File: rtl/reg_ctrl.sv
// reg_ctrl
// Decodes UART byte frames into register file accesses and returns read
// results as a single transmitted byte.
//   Write frame : 0xAA, addr, data
//   Read frame  : 0xBB, addr   -> read data sent back through the TX handshake
// Only the low ADDR bits of the address byte are used.
// Ports:
//   i_Ref_clk : reference clock, rising edge
//   i_rst     : asynchronous active-low reset
//   bus       : reg_ctrl_if.master (RX byte in, register file, TX byte out)
// Optional feature macro: REG_CTRL_ERR_EN
//   defined   -> unknown command bytes and read timeouts transmit 0xEE
//   undefined -> both are silently dropped
// All outputs come straight from registers.
module reg_ctrl
    import reg_ctrl_pkg::*;
#(
    parameter int WIDTH_REG  = 8,
    parameter int ADDR       = 4,
    parameter int RD_TIMEOUT = 4
) (
    input  logic        i_Ref_clk,
    input  logic        i_rst,
    reg_ctrl_if.master  bus
);

    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

    state_t               state_reg, state_next;
    logic [ADDR-1:0]      addr_reg, addr_next;
    logic [WIDTH_REG-1:0] wr_data_reg, wr_data_next;
    logic [WIDTH_REG-1:0] tx_data_reg, tx_data_next;   // TX holding register
    logic                 wr_en_reg, wr_en_next;
    logic                 rd_en_reg, rd_en_next;
    logic                 tx_valid_reg, tx_valid_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;           // cycles spent in RD_WAIT

    always_ff @(posedge i_Ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            wr_data_reg  <= '0;
            tx_data_reg  <= '0;
            wr_en_reg    <= 1'b0;
            rd_en_reg    <= 1'b0;
            tx_valid_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            wr_data_reg  <= wr_data_next;
            tx_data_reg  <= tx_data_next;
            wr_en_reg    <= wr_en_next;
            rd_en_reg    <= rd_en_next;
            tx_valid_reg <= tx_valid_next;
            cnt_reg      <= cnt_next;
        end
    end

    always_comb begin
        // Strobes default low so each is high for exactly one cycle.
        state_next    = state_reg;
        addr_next     = addr_reg;
        wr_data_next  = wr_data_reg;
        tx_data_next  = tx_data_reg;
        wr_en_next    = 1'b0;
        rd_en_next    = 1'b0;
        tx_valid_next = 1'b0;
        cnt_next      = cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (bus.i_rx_valid) begin
                    if (bus.i_rx_data == WIDTH_REG'(CMD_WR)) begin
                        state_next = ST_WR_ADDR;
                    end else if (bus.i_rx_data == WIDTH_REG'(CMD_RD)) begin
                        state_next = ST_RD_ADDR;
                    end else begin
`ifdef REG_CTRL_ERR_EN
                        tx_data_next = WIDTH_REG'(ERR_CODE);
                        state_next   = ST_TX_WAIT;
`else
                        state_next   = ST_IDLE;
`endif
                    end
                end
            end

            ST_WR_ADDR: begin
                if (bus.i_rx_valid) begin
                    addr_next  = bus.i_rx_data[ADDR-1:0];
                    state_next = ST_WR_DATA;
                end
            end

            ST_WR_DATA: begin
                if (bus.i_rx_valid) begin
                    wr_data_next = bus.i_rx_data;
                    wr_en_next   = 1'b1;
                    state_next   = ST_IDLE;
                end
            end

            ST_RD_ADDR: begin
                if (bus.i_rx_valid) begin
                    addr_next  = bus.i_rx_data[ADDR-1:0];
                    rd_en_next = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_RD_WAIT;
                end
            end

            ST_RD_WAIT: begin
                // Incoming RX bytes are deliberately ignored here.
                if (bus.i_rd_valid) begin
                    tx_data_next = bus.i_rd_data;
                    state_next   = ST_TX_WAIT;
                end else if (cnt_reg == CNT_W'(RD_TIMEOUT - 1)) begin
                    // This is the RD_TIMEOUT-th cycle with no response.
                    cnt_next = '0;
`ifdef REG_CTRL_ERR_EN
                    tx_data_next = WIDTH_REG'(ERR_CODE);
                    state_next   = ST_TX_WAIT;
`else
                    state_next   = ST_IDLE;
`endif
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_TX_WAIT: begin
                if (!bus.i_tx_busy) begin
                    tx_valid_next = 1'b1;
                    state_next    = ST_IDLE;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.o_addr     = addr_reg;
    assign bus.o_wr_en    = wr_en_reg;
    assign bus.o_rd_en    = rd_en_reg;
    assign bus.o_wr_data  = wr_data_reg;
    assign bus.o_tx_data  = tx_data_reg;
    assign bus.o_tx_valid = tx_valid_reg;

endmodule

// File: tb/tb_reg_ctrl.sv
// tb_reg_ctrl
// Self-checking bench for reg_ctrl: a frame-level reference model predicts
// every registered output each cycle, a register-file responder answers
// reads, and directed sequences pin the model with literal expectations
// before a randomized frame phase. Honours REG_CTRL_ERR_EN.
module tb_reg_ctrl;
    import reg_ctrl_pkg::*;

    localparam int RD_TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_ctrl_if #(.WIDTH_REG(8), .ADDR(4)) bus ();

    reg_ctrl #(.WIDTH_REG(8), .ADDR(4), .RD_TIMEOUT(RD_TIMEOUT)) dut (
        .i_Ref_clk (clk),
        .i_rst     (rst),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- register file responder ----------------
    logic [7:0] mem [16];
    bit         resp_en  = 1'b1;
    bit         noise_en = 1'b0;

    initial begin
        bit         rd_pend;
        logic [3:0] rd_addr_pend;
        rd_pend      = 1'b0;
        rd_addr_pend = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        bus.i_rd_valid = 1'b0;
        bus.i_rd_data  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            // valid answers a strobe seen one edge earlier; noise tests that
            // stray valids outside a read are ignored
            bus.i_rd_valid = (rd_pend && resp_en) || (noise_en && $urandom_range(0, 7) == 0);
            bus.i_rd_data  = rd_pend ? mem[rd_addr_pend] : 8'($urandom);
            if (bus.o_wr_en) mem[bus.o_addr] = bus.o_wr_data;
            rd_pend      = bus.o_rd_en;
            rd_addr_pend = bus.o_addr;
        end
    end

    // ---------------- frame-level reference model ----------------
    logic [3:0] m_addr;
    logic [7:0] m_wr_data, m_tx_data;
    bit         m_wr_en, m_rd_en, m_tx_valid;

    initial begin
        logic [7:0] frame [$];
        bit         rd_wait, tx_pend;
        int         waited;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                frame.delete();
                rd_wait = 0; tx_pend = 0; waited = 0;
                m_addr = '0; m_wr_data = '0; m_tx_data = '0;
                m_wr_en = 0; m_rd_en = 0; m_tx_valid = 0;
            end else begin
                m_wr_en = 0; m_rd_en = 0; m_tx_valid = 0;
                if (tx_pend) begin
                    if (!bus.i_tx_busy) begin
                        m_tx_valid = 1;
                        tx_pend    = 0;
                    end
                end else if (rd_wait) begin
                    if (bus.i_rd_valid) begin
                        m_tx_data = bus.i_rd_data;
                        tx_pend   = 1;
                        rd_wait   = 0;
                    end else begin
                        waited++;
                        if (waited == RD_TIMEOUT) begin
                            rd_wait = 0;
`ifdef REG_CTRL_ERR_EN
                            m_tx_data = 8'hEE;
                            tx_pend   = 1;
`endif
                        end
                    end
                end else if (bus.i_rx_valid) begin
                    frame.push_back(bus.i_rx_data);
                    if (frame[0] != 8'hAA && frame[0] != 8'hBB) begin
                        frame.delete();
`ifdef REG_CTRL_ERR_EN
                        m_tx_data = 8'hEE;
                        tx_pend   = 1;
`endif
                    end else if (frame.size() == 2) begin
                        m_addr = frame[1] % 16;
                        if (frame[0] == 8'hBB) begin
                            m_rd_en = 1;
                            rd_wait = 1;
                            waited  = 0;
                            frame.delete();
                        end
                    end else if (frame.size() == 3) begin
                        m_wr_data = frame[2];
                        m_wr_en   = 1;
                        frame.delete();
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("wr_en",    32'(bus.o_wr_en),    32'(m_wr_en));
                check("rd_en",    32'(bus.o_rd_en),    32'(m_rd_en));
                check("tx_valid", 32'(bus.o_tx_valid), 32'(m_tx_valid));
                check("addr",     32'(bus.o_addr),     32'(m_addr));
                check("wr_data",  32'(bus.o_wr_data),  32'(m_wr_data));
                check("tx_data",  32'(bus.o_tx_data),  32'(m_tx_data));
                check("strobe_excl", 32'(bus.o_wr_en & bus.o_rd_en), 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    bit busy_rand  = 1'b0;
    bit busy_force = 1'b0;

    task automatic drive(input bit v, input logic [7:0] d);
        @(negedge clk);
        bus.i_rx_valid = v;
        bus.i_rx_data  = d;
        bus.i_tx_busy  = busy_rand ? ($urandom_range(0, 2) == 0) : busy_force;
    endtask

    task automatic send(input logic [7:0] d);
        drive(1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"},     32'(bus.o_addr),     32'd0);
        check({tag, "_wr_en"},    32'(bus.o_wr_en),    32'd0);
        check({tag, "_rd_en"},    32'(bus.o_rd_en),    32'd0);
        check({tag, "_wr_data"},  32'(bus.o_wr_data),  32'd0);
        check({tag, "_tx_data"},  32'(bus.o_tx_data),  32'd0);
        check({tag, "_tx_valid"}, 32'(bus.o_tx_valid), 32'd0);
    endtask

    initial begin
        int lat, pulses, wr_seen;
        logic [7:0] got;

        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        bus.i_tx_busy  = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        chk_en = 1'b1;
        rst = 1'b1;
        idle(2);

        // write frame
        send(8'hAA); send(8'h05); send(8'h3C);
        idle(1);
        $display("write AA 05 3C: wr_en=%0b addr=%0h data=%0h", bus.o_wr_en, bus.o_addr, bus.o_wr_data);
        check("wr_pulse",  32'(bus.o_wr_en),   32'd1);
        check("wr_addr",   32'(bus.o_addr),    32'd5);
        check("wr_data_v", 32'(bus.o_wr_data), 32'h3C);
        check("wr_no_rd",  32'(bus.o_rd_en),   32'd0);
        idle(1);
        check("wr_one_cycle", 32'(bus.o_wr_en), 32'd0);

        // address masking
        send(8'hAA); send(8'hF7); send(8'h11);
        idle(1);
        $display("write AA F7 11: addr=%0h", bus.o_addr);
        check("mask_addr", 32'(bus.o_addr),    32'd7);
        check("mask_data", 32'(bus.o_wr_data), 32'h11);

        // preload register values used by the reads
        send(8'hAA); send(8'h02); send(8'h81); idle(1);
        send(8'hAA); send(8'h00); send(8'h05); idle(2);

        // read with idle transmitter
        send(8'hBB); send(8'h02);
        idle(1);
        check("rd_pulse", 32'(bus.o_rd_en), 32'd1);
        check("rd_addr",  32'(bus.o_addr),  32'd2);
        lat = 0; pulses = 0; got = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            idle(1);
            if (bus.o_tx_valid) begin
                pulses++;
                got = bus.o_tx_data;
                if (lat == 0) lat = i;
            end
        end
        $display("read BB 02: tx=%0h latency=%0d pulses=%0d", got, lat, pulses);
        check("rd_latency", 32'(lat),    32'd3);
        check("rd_txdata",  32'(got),    32'h81);
        check("rd_pulses",  32'(pulses), 32'd1);

        // transmitter busy backpressure with dropped bytes
        busy_force = 1'b1;
        send(8'hBB); send(8'h00);
        pulses = 0; wr_seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 3)      send(8'hAA);
            else if (c == 5) send(8'h01);
            else if (c == 7) send(8'h99);
            else             idle(1);
            if (bus.o_tx_valid) pulses++;
            if (bus.o_wr_en)    wr_seen++;
        end
        check("busy_no_tx", 32'(pulses), 32'd0);
        busy_force = 1'b0;
        idle(1);
        check("busy_still_held", 32'(bus.o_tx_valid), 32'd0);
        idle(1);
        $display("busy read 00: tx_valid=%0b tx=%0h", bus.o_tx_valid, bus.o_tx_data);
        check("busy_tx_valid", 32'(bus.o_tx_valid), 32'd1);
        check("busy_tx_data",  32'(bus.o_tx_data),  32'h05);
        idle(1);
        if (bus.o_wr_en) wr_seen++;
        check("busy_tx_once",  32'(bus.o_tx_valid), 32'd0);
        idle(3);
        check("busy_dropped_no_wr", 32'(wr_seen), 32'd0);

        // read timeout
        resp_en = 1'b0;
        send(8'hBB); send(8'h01);
        idle(1);
        lat = 0; pulses = 0; got = 8'h00;
        for (int i = 1; i <= 10; i++) begin
            idle(1);
            if (bus.o_tx_valid) begin
                pulses++;
                got = bus.o_tx_data;
                if (lat == 0) lat = i;
            end
        end
        resp_en = 1'b1;
        $display("timeout BB 01: pulses=%0d tx=%0h latency=%0d", pulses, got, lat);
`ifdef REG_CTRL_ERR_EN
        check("to_pulses",  32'(pulses), 32'd1);
        check("to_errbyte", 32'(got),    32'hEE);
        check("to_latency", 32'(lat),    32'd5);
`else
        check("to_pulses",  32'(pulses), 32'd0);
`endif

        // unknown command byte
        send(8'h55);
        lat = 0; pulses = 0; got = 8'h00;
        for (int i = 1; i <= 6; i++) begin
            idle(1);
            if (bus.o_tx_valid) begin
                pulses++;
                got = bus.o_tx_data;
                if (lat == 0) lat = i;
            end
        end
        $display("unknown 55: pulses=%0d tx=%0h", pulses, got);
`ifdef REG_CTRL_ERR_EN
        check("unk_pulses",  32'(pulses), 32'd1);
        check("unk_errbyte", 32'(got),    32'hEE);
        check("unk_latency", 32'(lat),    32'd2);
`else
        check("unk_pulses",  32'(pulses), 32'd0);
`endif

        // reset mid-frame, including while a write strobe is high
        send(8'hAA); send(8'h03);
        idle(1);
        check("mid_addr_set", 32'(bus.o_addr), 32'd3);
        send(8'h44);
        @(posedge clk);
        #2;
        check("mid_wr_high", 32'(bus.o_wr_en), 32'd1);
        rst = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        send(8'hAA); send(8'h03);
        rst = 1'b0;
        @(posedge clk);
        #2;
        check_all_zero("frame_reset");
        @(negedge clk);
        rst = 1'b1;
        send(8'h77);
        wr_seen = 0;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            if (bus.o_wr_en) wr_seen++;
        end
        $display("reset mid-frame then 77: writes=%0d", wr_seen);
        check("after_reset_no_wr", 32'(wr_seen), 32'd0);
        idle(4);

        // randomized frames against the model
        busy_rand = 1'b1;
        noise_en  = 1'b1;
        for (int f = 0; f < 250; f++) begin
            int kind;
            int nb;
            logic [7:0] b [3];
            kind    = $urandom_range(0, 9);
            resp_en = ($urandom_range(0, 7) != 0);
            nb = 0;
            if (kind <= 3) begin
                b[0] = 8'hAA; b[1] = 8'($urandom); b[2] = 8'($urandom); nb = 3;
            end else if (kind <= 6) begin
                b[0] = 8'hBB; b[1] = 8'($urandom); nb = 2;
            end else if (kind == 7) begin
                b[0] = 8'($urandom); nb = 1;
            end else if (kind == 8) begin
                b[0] = 8'hAA; nb = 1;
            end else begin
                nb = $urandom_range(1, 3);
                for (int j = 0; j < nb; j++) b[j] = 8'($urandom);
            end
            for (int j = 0; j < nb; j++) begin
                send(b[j]);
                idle($urandom_range(0, 2));
            end
            idle($urandom_range(0, 8));
            $display("random frame %0d kind=%0d bytes=%0d", f, kind, nb);
        end
        busy_rand  = 1'b0;
        busy_force = 1'b0;
        noise_en   = 1'b0;
        resp_en    = 1'b1;
        idle(20);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
